i3c_frame_bit_counter: RTL and testbench

Parametrised, mode-aware successor to the HDR bit counter in the I3C target/controller datapath. It counts qualified SCL edge strobes: positive edges in SDR, both edges in HDR-DDR. It wraps at a per-mode frame length and raises last-bit and word-done strobes for the framing FSMs. It also keeps a saturating word count per transfer and covers the HDR error-recovery pattern with its own length.

---
 rtl/i3c_bitcnt_pkg.sv | 21 ++
 rtl/i3c_frame_bit_counter.sv | 147 ++++++++++++++
 tb/tb_i3c_frame_bit_counter.sv | 358 +++++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/i3c_bitcnt_pkg.sv
// Shared types and default frame lengths for the I3C frame bit counter.
package i3c_bitcnt_pkg;

    typedef enum logic [1:0] {
        MODE_SDR  = 2'b00,
        MODE_DDR  = 2'b01,
        MODE_ERR  = 2'b10,
        MODE_HOLD = 2'b11
    } mode_e;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'b00,
        ST_COUNT = 2'b01,
        ST_ERR   = 2'b10
    } state_e;

    localparam int SDR_BITS = 9;   // 8 data + T-bit
    localparam int DDR_BITS = 20;  // preamble + 16 data + parity
    localparam int ERR_BITS = 38;  // HDR error-recovery pattern

endpackage

// File: rtl/i3c_frame_bit_counter.sv
// Mode-aware SCL edge counter: wraps at a per-mode frame length, flags the last
// bit and frame completion, and keeps a saturating per-transfer word count.
module i3c_frame_bit_counter #(
    parameter int CNT_W    = 6,
    parameter int SDR_BITS = i3c_bitcnt_pkg::SDR_BITS,
    parameter int DDR_BITS = i3c_bitcnt_pkg::DDR_BITS,
    parameter int ERR_BITS = i3c_bitcnt_pkg::ERR_BITS,
    parameter int WCNT_W   = 8
) (
    input  logic              i_sys_clk,
    input  logic              i_rst_n,
    input  logic              i_cnt_en,
    input  logic [1:0]        i_mode,
    input  logic              i_scl_pos_edge,
    input  logic              i_scl_neg_edge,
    input  logic              i_len_ovr_en,
    input  logic [CNT_W-1:0]  i_len_ovr,
    output logic [CNT_W-1:0]  o_bit_cnt,
    output logic              o_last_bit,
    output logic              o_word_done,
    output logic [WCNT_W-1:0] o_word_cnt,
    output logic              o_word_ovf,
    output logic              o_busy
);
    import i3c_bitcnt_pkg::*;

    state_e              state_q, state_d;
    mode_e               mode_q, mode_d;
    mode_e               mode_in;
    logic [CNT_W-1:0]    len_m1_q, len_m1_d;
    logic [CNT_W-1:0]    sel_len_m1;
    logic [CNT_W-1:0]    bit_cnt_q, bit_cnt_d;
    logic                last_q, last_d;
    logic                done_q, done_d;
    logic [WCNT_W-1:0]   wcnt_q, wcnt_d;
    logic                ovf_q, ovf_d;
    logic                edge_ok;
    logic                mode_change;

    assign mode_in = mode_e'(i_mode);

    // Length is held as its last index so a full 2**CNT_W frame still fits.
    always_comb begin
        sel_len_m1 = CNT_W'(SDR_BITS - 1);
        if (i_len_ovr_en) begin
            sel_len_m1 = (i_len_ovr < CNT_W'(2)) ? CNT_W'(1) : i_len_ovr - CNT_W'(1);
        end else begin
            case (mode_in)
                MODE_DDR: sel_len_m1 = CNT_W'(DDR_BITS - 1);
                MODE_ERR: sel_len_m1 = CNT_W'(ERR_BITS - 1);
                default:  sel_len_m1 = CNT_W'(SDR_BITS - 1);
            endcase
        end
    end

    // SDR counts rising edges only; DDR/ERR count either edge, a coincident pair once.
    always_comb begin
        edge_ok = 1'b0;
        case (mode_in)
            MODE_SDR:  edge_ok = i_scl_pos_edge;
            MODE_HOLD: edge_ok = 1'b0;
            default:   edge_ok = i_scl_pos_edge | i_scl_neg_edge;
        endcase
    end

    // HOLD is not a mode change; it only pauses the active mode.
    assign mode_change = (mode_in != MODE_HOLD) && (mode_in != mode_q);

    // NOTE: every always_comb output gets a default first so no latch is inferred.
    always_comb begin
        state_d   = state_q;
        mode_d    = mode_q;
        len_m1_d  = len_m1_q;
        bit_cnt_d = bit_cnt_q;
        done_d    = 1'b0;
        wcnt_d    = wcnt_q;
        ovf_d     = ovf_q;

        if (!i_cnt_en) begin
            state_d   = ST_IDLE;
            bit_cnt_d = '0;
            wcnt_d    = '0;
            ovf_d     = 1'b0;
        end else begin
            case (state_q)
                ST_IDLE: begin
                    state_d   = (mode_in == MODE_ERR) ? ST_ERR : ST_COUNT;
                    mode_d    = (mode_in == MODE_HOLD) ? MODE_SDR : mode_in;
                    len_m1_d  = sel_len_m1;
                    bit_cnt_d = '0;
                end
                default: begin
                    if (mode_change) begin
                        state_d   = (mode_in == MODE_ERR) ? ST_ERR : ST_COUNT;
                        mode_d    = mode_in;
                        len_m1_d  = sel_len_m1;
                        bit_cnt_d = '0;
                    end else if (edge_ok) begin
                        if (bit_cnt_q == len_m1_q) begin
                            bit_cnt_d = '0;
                            done_d    = 1'b1;
                            if (wcnt_q != '1) begin
                                wcnt_d = wcnt_q + WCNT_W'(1);
                                ovf_d  = ovf_q | (&wcnt_d);
                            end
                        end else begin
                            bit_cnt_d = bit_cnt_q + CNT_W'(1);
                        end
                    end
                end
            endcase
        end

        last_d = (state_d != ST_IDLE) && (bit_cnt_d == len_m1_d);
    end

    // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
    always_ff @(posedge i_sys_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            state_q   <= ST_IDLE;
            mode_q    <= MODE_SDR;
            len_m1_q  <= '0;
            bit_cnt_q <= '0;
            last_q    <= 1'b0;
            done_q    <= 1'b0;
            wcnt_q    <= '0;
            ovf_q     <= 1'b0;
        end else begin
            state_q   <= state_d;
            mode_q    <= mode_d;
            len_m1_q  <= len_m1_d;
            bit_cnt_q <= bit_cnt_d;
            last_q    <= last_d;
            done_q    <= done_d;
            wcnt_q    <= wcnt_d;
            ovf_q     <= ovf_d;
        end
    end

    assign o_bit_cnt   = bit_cnt_q;
    assign o_last_bit  = last_q;
    assign o_word_done = done_q;
    assign o_word_cnt  = wcnt_q;
    assign o_word_ovf  = ovf_q;
    assign o_busy      = (state_q != ST_IDLE);

endmodule

// File: tb/tb_i3c_frame_bit_counter.sv
// Self-checking bench for i3c_frame_bit_counter: directed scenarios plus a
// randomized run, all scored against a frame-level reference model.
module tb_i3c_frame_bit_counter;

    localparam int CNT_W  = 6;
    localparam int WCNT_W = 8;
    localparam int SAT_W  = 2;

    logic              i_sys_clk = 1'b0;
    logic              i_rst_n;
    logic              cnt_en;
    logic [1:0]        mode;
    logic              scl_pos;
    logic              scl_neg;
    logic              ovr_en;
    logic [CNT_W-1:0]  ovr;

    logic [CNT_W-1:0]  bit_cnt;
    logic              last_bit, word_done, word_ovf, busy;
    logic [WCNT_W-1:0] word_cnt;

    logic [CNT_W-1:0]  s_bit_cnt;
    logic              s_last_bit, s_word_done, s_word_ovf, s_busy;
    logic [SAT_W-1:0]  s_word_cnt;

    int n_vec = 0;
    int n_err = 0;

    // Reference model: frame position, frame length and completed frames.
    bit m_active;
    int m_mode;
    int m_len;
    int m_cnt;
    int m_words;
    bit m_done;

    always #5 i_sys_clk = ~i_sys_clk;

    i3c_frame_bit_counter #(.CNT_W(CNT_W), .WCNT_W(WCNT_W)) dut (
        .i_sys_clk      (i_sys_clk),
        .i_rst_n        (i_rst_n),
        .i_cnt_en       (cnt_en),
        .i_mode         (mode),
        .i_scl_pos_edge (scl_pos),
        .i_scl_neg_edge (scl_neg),
        .i_len_ovr_en   (ovr_en),
        .i_len_ovr      (ovr),
        .o_bit_cnt      (bit_cnt),
        .o_last_bit     (last_bit),
        .o_word_done    (word_done),
        .o_word_cnt     (word_cnt),
        .o_word_ovf     (word_ovf),
        .o_busy         (busy)
    );

    i3c_frame_bit_counter #(.CNT_W(CNT_W), .WCNT_W(SAT_W)) dut_sat (
        .i_sys_clk      (i_sys_clk),
        .i_rst_n        (i_rst_n),
        .i_cnt_en       (cnt_en),
        .i_mode         (mode),
        .i_scl_pos_edge (scl_pos),
        .i_scl_neg_edge (scl_neg),
        .i_len_ovr_en   (ovr_en),
        .i_len_ovr      (ovr),
        .o_bit_cnt      (s_bit_cnt),
        .o_last_bit     (s_last_bit),
        .o_word_done    (s_word_done),
        .o_word_cnt     (s_word_cnt),
        .o_word_ovf     (s_word_ovf),
        .o_busy         (s_busy)
    );

    function automatic int pick_len(input int md, input bit oe, input int ov);
        if (oe) return (ov < 2) ? 2 : ov;
        case (md)
            1:       return 20;
            2:       return 38;
            default: return 9;
        endcase
    endfunction

    function automatic int sat(input int words, input int w);
        int max = (1 << w) - 1;
        return (words > max) ? max : words;
    endfunction

    task automatic model_reset();
        m_active = 0; m_mode = 0; m_len = 9; m_cnt = 0; m_words = 0; m_done = 0;
    endtask

    task automatic model_clock();
        m_done = 0;
        if (!cnt_en) begin
            m_active = 0; m_cnt = 0; m_words = 0;
        end else if (!m_active) begin
            m_active = 1;
            m_mode   = (mode == 2'd3) ? 0 : int'(mode);
            m_len    = pick_len(int'(mode), ovr_en, int'(ovr));
            m_cnt    = 0;
        end else if (mode != 2'd3) begin
            if (int'(mode) != m_mode) begin
                m_mode = int'(mode);
                m_len  = pick_len(int'(mode), ovr_en, int'(ovr));
                m_cnt  = 0;
            end else if (scl_pos || (mode != 2'd0 && scl_neg)) begin
                m_cnt = m_cnt + 1;
                if (m_cnt == m_len) begin
                    m_cnt   = 0;
                    m_done  = 1;
                    m_words = m_words + 1;
                end
            end
        end
    endtask

    // Drive one system-clock cycle of strobes; outputs are then sampled at the falling edge.
    task automatic step(input logic p, input logic n);
        scl_pos = p;
        scl_neg = n;
        @(posedge i_sys_clk);
        if (i_rst_n) model_clock();
        @(negedge i_sys_clk);
        scl_pos = 1'b0;
        scl_neg = 1'b0;
    endtask

    task automatic clear_block();
        cnt_en = 1'b0;
        step(1'b0, 1'b0);
    endtask

    task automatic test_reset();
        model_reset();
        i_rst_n = 1'b0; cnt_en = 1'b0; mode = 2'd0;
        scl_pos = 1'b0; scl_neg = 1'b0; ovr_en = 1'b0; ovr = '0;
        repeat (2) @(negedge i_sys_clk);
        n_vec++;
        if ({bit_cnt, last_bit, word_done, word_cnt, word_ovf, busy} !== '0) begin
            n_err++;
            $display("FAIL reset_main: got %h expected 0", {bit_cnt, last_bit, word_done, word_cnt, word_ovf, busy});
        end
        n_vec++;
        if ({s_bit_cnt, s_last_bit, s_word_done, s_word_cnt, s_word_ovf, s_busy} !== '0) begin
            n_err++;
            $display("FAIL reset_sat: got %h expected 0", {s_bit_cnt, s_last_bit, s_word_done, s_word_cnt, s_word_ovf, s_busy});
        end
        i_rst_n = 1'b1;
        step(1'b0, 1'b0);
    endtask

    task automatic test_ddr();
        clear_block();
        mode = 2'd1; cnt_en = 1'b1;
        step(1'b0, 1'b0);
        for (int i = 1; i <= 40; i++) begin
            step(i[0], ~i[0]);
            n_vec++;
            if (bit_cnt !== CNT_W'(i % 20) || bit_cnt !== CNT_W'(m_cnt)) begin
                n_err++;
                $display("FAIL ddr_cnt[%0d]: got %0d expected %0d", i, bit_cnt, i % 20);
            end
            n_vec++;
            if (word_done !== (i % 20 == 0) || last_bit !== (i % 20 == 19)) begin
                n_err++;
                $display("FAIL ddr_flags[%0d]: got done=%b last=%b expected done=%b last=%b",
                         i, word_done, last_bit, i % 20 == 0, i % 20 == 19);
            end
        end
        n_vec++;
        if (word_cnt !== 8'd2) begin
            n_err++;
            $display("FAIL ddr_words: got %0d expected 2", word_cnt);
        end
    endtask

    task automatic test_sdr();
        clear_block();
        mode = 2'd0; cnt_en = 1'b1;
        step(1'b0, 1'b0);
        for (int i = 0; i < 18; i++) begin
            step(i % 2 == 0, i % 2 == 1);
            n_vec++;
            if (bit_cnt !== CNT_W'(m_cnt) || last_bit !== (m_cnt == 8) || word_done !== m_done) begin
                n_err++;
                $display("FAIL sdr[%0d]: got cnt=%0d last=%b done=%b expected cnt=%0d last=%b done=%b",
                         i, bit_cnt, last_bit, word_done, m_cnt, m_cnt == 8, m_done);
            end
        end
        n_vec++;
        if (word_cnt !== 8'd1 || bit_cnt !== '0) begin
            n_err++;
            $display("FAIL sdr_wrap: got words=%0d cnt=%0d expected words=1 cnt=0", word_cnt, bit_cnt);
        end
    endtask

    task automatic test_err_switch();
        int n_done = 0;
        clear_block();
        mode = 2'd2; cnt_en = 1'b1;
        step(1'b0, 1'b0);
        n_vec++;
        if (busy !== 1'b1) begin
            n_err++;
            $display("FAIL err_busy: got %b expected 1", busy);
        end
        for (int i = 0; i < 38; i++) begin
            int k = $urandom_range(1, 3);
            step(k[0], k[1]);
            if (word_done) n_done++;
        end
        n_vec++;
        if (n_done != 1 || bit_cnt !== '0 || word_cnt !== 8'd1) begin
            n_err++;
            $display("FAIL err_wrap: got done=%0d cnt=%0d words=%0d expected done=1 cnt=0 words=1",
                     n_done, bit_cnt, word_cnt);
        end
        for (int i = 0; i < 5; i++) step(1'b1, 1'b0);
        mode = 2'd1;
        step(1'b1, 1'b1);
        n_vec++;
        if (bit_cnt !== '0 || word_done !== 1'b0 || word_cnt !== 8'd1 || busy !== 1'b1) begin
            n_err++;
            $display("FAIL err_to_ddr: got cnt=%0d done=%b words=%0d busy=%b expected 0/0/1/1",
                     bit_cnt, word_done, word_cnt, busy);
        end
        step(1'b1, 1'b0);
        n_vec++;
        if (bit_cnt !== CNT_W'(1)) begin
            n_err++;
            $display("FAIL err_to_ddr_next: got %0d expected 1", bit_cnt);
        end
    endtask

    task automatic test_override();
        clear_block();
        mode = 2'd1; ovr_en = 1'b1; ovr = '0; cnt_en = 1'b1;
        step(1'b0, 1'b0);
        for (int k = 1; k <= 6; k++) begin
            step(1'b1, 1'b1);
            n_vec++;
            if (bit_cnt !== CNT_W'(k % 2) || word_done !== (k % 2 == 0) || last_bit !== (k % 2 == 1)) begin
                n_err++;
                $display("FAIL ovr[%0d]: got cnt=%0d done=%b last=%b expected cnt=%0d done=%b last=%b",
                         k, bit_cnt, word_done, last_bit, k % 2, k % 2 == 0, k % 2 == 1);
            end
        end
        ovr_en = 1'b0;
    endtask

    task automatic test_saturation();
        clear_block();
        mode = 2'd1; cnt_en = 1'b1;
        step(1'b0, 1'b0);
        for (int i = 0; i < 100; i++) step(1'b1, 1'b0);
        n_vec++;
        if (s_word_cnt !== 2'd3 || s_word_ovf !== 1'b1) begin
            n_err++;
            $display("FAIL sat_w2: got words=%0d ovf=%b expected words=3 ovf=1", s_word_cnt, s_word_ovf);
        end
        n_vec++;
        if (word_cnt !== 8'd5 || word_ovf !== 1'b0) begin
            n_err++;
            $display("FAIL sat_w8: got words=%0d ovf=%b expected words=5 ovf=0", word_cnt, word_ovf);
        end
        cnt_en = 1'b0;
        step(1'b1, 1'b0);
        n_vec++;
        if ({bit_cnt, last_bit, word_done, word_cnt, word_ovf, busy, s_word_cnt, s_word_ovf} !== '0) begin
            n_err++;
            $display("FAIL sat_clear: got cnt=%0d words=%0d ovf=%b busy=%b swords=%0d sovf=%b expected all 0",
                     bit_cnt, word_cnt, word_ovf, busy, s_word_cnt, s_word_ovf);
        end
    endtask

    task automatic test_reset_mid();
        clear_block();
        mode = 2'd1; cnt_en = 1'b1;
        step(1'b0, 1'b0);
        for (int i = 0; i < 11; i++) step(1'b0, 1'b1);
        n_vec++;
        if (bit_cnt !== CNT_W'(11)) begin
            n_err++;
            $display("FAIL rst_mid_pre: got %0d expected 11", bit_cnt);
        end
        #2 i_rst_n = 1'b0;
        model_reset();
        #1;
        n_vec++;
        if ({bit_cnt, last_bit, word_done, word_cnt, word_ovf, busy} !== '0) begin
            n_err++;
            $display("FAIL rst_mid_async: got cnt=%0d busy=%b done=%b expected all 0", bit_cnt, busy, word_done);
        end
        @(negedge i_sys_clk);
        i_rst_n = 1'b1;
        step(1'b1, 1'b0);
        n_vec++;
        if (bit_cnt !== '0 || busy !== 1'b1) begin
            n_err++;
            $display("FAIL rst_mid_enable: got cnt=%0d busy=%b expected cnt=0 busy=1", bit_cnt, busy);
        end
        step(1'b1, 1'b0);
        n_vec++;
        if (bit_cnt !== CNT_W'(1)) begin
            n_err++;
            $display("FAIL rst_mid_first: got %0d expected 1", bit_cnt);
        end
    endtask

    task automatic test_random();
        clear_block();
        cnt_en = 1'b1; mode = 2'd1;
        for (int i = 0; i < 400; i++) begin
            if ($urandom_range(0, 49) == 0) cnt_en = ~cnt_en;
            if ($urandom_range(0, 19) == 0) mode = 2'($urandom_range(0, 3));
            if ($urandom_range(0, 9) == 0) begin
                ovr_en = 1'($urandom_range(0, 1));
                ovr    = CNT_W'($urandom_range(0, 12));
            end
            step(1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)));
            n_vec++;
            if (bit_cnt !== CNT_W'(m_cnt) || s_bit_cnt !== CNT_W'(m_cnt)) begin
                n_err++;
                $display("FAIL rnd_cnt[%0d]: got %0d/%0d expected %0d", i, bit_cnt, s_bit_cnt, m_cnt);
            end
            n_vec++;
            if (last_bit !== (m_active && m_cnt == m_len - 1) || word_done !== m_done || busy !== m_active) begin
                n_err++;
                $display("FAIL rnd_flags[%0d]: got last=%b done=%b busy=%b expected last=%b done=%b busy=%b",
                         i, last_bit, word_done, busy, m_active && m_cnt == m_len - 1, m_done, m_active);
            end
            n_vec++;
            if (word_cnt !== WCNT_W'(sat(m_words, WCNT_W)) || word_ovf !== (m_words >= 255)) begin
                n_err++;
                $display("FAIL rnd_words[%0d]: got %0d ovf=%b expected %0d", i, word_cnt, word_ovf, m_words);
            end
            n_vec++;
            if (s_word_cnt !== SAT_W'(sat(m_words, SAT_W)) || s_word_ovf !== (m_words >= 3)) begin
                n_err++;
                $display("FAIL rnd_sat[%0d]: got %0d ovf=%b expected %0d ovf=%b",
                         i, s_word_cnt, s_word_ovf, sat(m_words, SAT_W), m_words >= 3);
            end
        end
    endtask

    initial begin
        test_reset();
        test_ddr();
        test_sdr();
        test_err_switch();
        test_override();
        test_saturation();
        test_reset_mid();
        test_random();
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
